// File: rtl/regfile_8x8.sv
// ----------------------------------------------------------------------------
// regfile_8x8 : 8 x 8-bit register file, one synchronous write port and two
//               combinational read ports with optional write-through bypass.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_8x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int c_num_regs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [c_num_regs];
  logic [DATA_WIDTH-1:0] mem_d [c_num_regs];

  always_comb begin
    for (int i = 0; i < c_num_regs; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Reset wins over a same-edge write: the write computed in mem_d is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_num_regs; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_num_regs; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign rdata1 = (we && (raddr1 == waddr)) ? wdata : mem_q[raddr1];
      assign rdata2 = (we && (raddr2 == waddr)) ? wdata : mem_q[raddr2];
    end else begin : g_no_bypass
      assign rdata1 = mem_q[raddr1];
      assign rdata2 = mem_q[raddr2];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_8x8.sv
// ----------------------------------------------------------------------------
// tb_regfile_8x8 : directed self-checking bench driving a BYPASS=0 and a
//                  BYPASS=1 instance of regfile_8x8 from the same stimulus.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_8x8;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr1;
  logic [2:0] raddr2;
  logic [7:0] rdata1_b0, rdata2_b0;
  logic [7:0] rdata1_b1, rdata2_b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_mem [8];

  regfile_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0)) u_dut_b0 (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_b0),
    .rdata2 (rdata2_b0)
  );

  regfile_8x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1)) u_dut_b1 (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1_b1),
    .rdata2 (rdata2_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

    // 1. reset clears everything
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(7 - i);
      #1;
      check($sformatf("rst_b0_p1_r%0d", i), rdata1_b0, 8'h00);
      check($sformatf("rst_b0_p2_r%0d", 7 - i), rdata2_b0, 8'h00);
      check($sformatf("rst_b1_p1_r%0d", i), rdata1_b1, 8'h00);
      check($sformatf("rst_b1_p2_r%0d", 7 - i), rdata2_b1, 8'h00);
    end

    // 2. two writes, then read back on both ports
    we = 1'b1; waddr = 3'd1; wdata = 8'hAA;
    tick();
    waddr = 3'd2; wdata = 8'h55;
    tick();
    we = 1'b0; raddr1 = 3'd1; raddr2 = 3'd2;
    #1;
    check("wr_b0_r1", rdata1_b0, 8'hAA);
    check("wr_b0_r2", rdata2_b0, 8'h55);
    check("wr_b1_r1", rdata1_b1, 8'hAA);
    check("wr_b1_r2", rdata2_b1, 8'h55);

    // 3. we=0 must not write
    waddr = 3'd3; wdata = 8'hFF;
    tick();
    raddr1 = 3'd3;
    #1;
    check("nowe_b0_r3", rdata1_b0, 8'h00);
    check("nowe_b1_r3", rdata1_b1, 8'h00);
    raddr1 = 3'd1;
    #1;
    check("nowe_b0_r1", rdata1_b0, 8'hAA);
    check("nowe_b0_r2", rdata2_b0, 8'h55);

    // 4. same-cycle write/read of reg1; port 2 on another register is unaffected
    we = 1'b1; waddr = 3'd1; wdata = 8'h3C; raddr1 = 3'd1; raddr2 = 3'd2;
    #1;
    check("byp_pre_b0_r1", rdata1_b0, 8'hAA);
    check("byp_pre_b1_r1", rdata1_b1, 8'h3C);
    check("byp_pre_b1_r2", rdata2_b1, 8'h55);
    tick();
    we = 1'b0;
    #1;
    check("byp_post_b0_r1", rdata1_b0, 8'h3C);
    check("byp_post_b1_r1", rdata1_b1, 8'h3C);

    // 5. fill all registers; port 2 watches the register being written
    exp_mem[0] = 8'h00; exp_mem[1] = 8'h3C; exp_mem[2] = 8'h55; exp_mem[3] = 8'h00;
    exp_mem[4] = 8'h00; exp_mem[5] = 8'h00; exp_mem[6] = 8'h00; exp_mem[7] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 8'h10 + 8'(i); raddr2 = 3'(i);
      #1;
      check($sformatf("fill_pre_b0_r%0d", i), rdata2_b0, exp_mem[i]);
      check($sformatf("fill_pre_b1_r%0d", i), rdata2_b1, 8'h10 + 8'(i));
      tick();
      exp_mem[i] = 8'h10 + 8'(i);
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(7 - i);
      #1;
      check($sformatf("sweep_b0_p1_r%0d", i), rdata1_b0, 8'h10 + 8'(i));
      check($sformatf("sweep_b0_p2_r%0d", 7 - i), rdata2_b0, 8'h17 - 8'(i));
      check($sformatf("sweep_b1_p1_r%0d", i), rdata1_b1, 8'h10 + 8'(i));
      check($sformatf("sweep_b1_p2_r%0d", 7 - i), rdata2_b1, 8'h17 - 8'(i));
    end
    raddr1 = 3'd5; raddr2 = 3'd5;
    #1;
    check("same_b0_p1", rdata1_b0, 8'h15);
    check("same_b0_p2", rdata2_b0, 8'h15);
    check("same_b1_p1", rdata1_b1, 8'h15);
    check("same_b1_p2", rdata2_b1, 8'h15);

    // 6. reset has priority over a same-edge write
    rst = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'h77;
    tick();
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr1 = 3'(i);
      raddr2 = 3'(i);
      #1;
      check($sformatf("rstwr_b0_r%0d", i), rdata1_b0, 8'h00);
      check($sformatf("rstwr_b1_r%0d", i), rdata2_b1, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
